counter_load_sequencer: RTL and testbench

COUNTER_LOAD_SEQUENCER -- requirements
Module: counter_load_sequencer

---
 rtl/counter_load_sequencer.sv | 124 ++++++++++++
 tb/tb_counter_load_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_load_sequencer.sv
// Command sequencer driving a loadable up-counter: LOAD, ZERO, RUN (N increments) and NOP.
// Optional macro CARRY_STOP_EN ends a RUN on the first counter carry.
module counter_load_sequencer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cnt_clear,
    output logic             cnt_load,
    output logic             cnt_increment,
    output logic [WIDTH-1:0] cnt_I,
    input  logic             cnt_carry,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] carry_count
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_RUN  = 2'b10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ZERO = 3'd2,
        RUN  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [WIDTH-1:0]   cnt_i_q, cnt_i_d;
    logic [LEN_W-1:0]   cc_q, cc_d;
    logic               ready_q, busy_q, done_q;
    logic               load_q, clr_q, inc_q;

    // Next-state, remaining-length, load-data and carry-count logic
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_i_d = cnt_i_q;
        cc_d    = cc_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && ready_q) begin
                    case (cmd_op)
                        OP_NOP:  state_d = DONE;
                        OP_LOAD: begin
                            state_d = LOAD;
                            cnt_i_d = cmd_data;
                        end
                        OP_RUN: begin
                            cc_d    = '0;
                            len_d   = cmd_len;
                            state_d = (cmd_len == '0) ? DONE : RUN;
                        end
                        default: state_d = ZERO;
                    endcase
                end
            end
            LOAD, ZERO: state_d = DONE;
            RUN: begin
                // Carry only counts while incrementing; saturates at all-ones
                if (cnt_carry && (cc_q != '1)) begin
                    cc_d = cc_q + LEN_W'(1);
                end
                len_d = len_q - LEN_W'(1);
                if (len_q == LEN_W'(1)) begin
                    state_d = DONE;
                end
`ifdef CARRY_STOP_EN
                if (cnt_carry) begin
                    state_d = DONE;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; outputs registered from the next state so they align with it
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_i_q <= '0;
            cc_q    <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            load_q  <= 1'b0;
            clr_q   <= 1'b0;
            inc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_i_q <= cnt_i_d;
            cc_q    <= cc_d;
            ready_q <= (state_d == IDLE);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            load_q  <= (state_d == LOAD);
            clr_q   <= (state_d == ZERO);
            inc_q   <= (state_d == RUN);
        end
    end

    assign cmd_ready     = ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign cnt_load      = load_q;
    assign cnt_clear     = clr_q;
    assign cnt_increment = inc_q;
    assign cnt_I         = cnt_i_q;
    assign carry_count   = cc_q;

endmodule

// File: tb/tb_counter_load_sequencer.sv
// Bench for counter_load_sequencer: attached counter, arithmetic expectation queue, directed commands.
module tb_counter_load_sequencer;

    logic       clock = 1'b0;
    logic       clear;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [7:0] cmd_len;
    logic       cnt_clear, cnt_load, cnt_increment;
    logic [3:0] cnt_I;
    logic       cnt_carry;
    logic       busy, done;
    logic [7:0] carry_count;

    int vectors    = 0;
    int miscompares = 0;
    int inc_seen   = 0;
    int clr_seen   = 0;
    bit chk_en     = 1'b0;
    logic force_carry = 1'b0;
    logic [3:0] ctr_a;

    always #5 clock = ~clock;

    counter_load_sequencer #(.WIDTH(4), .LEN_W(8)) dut (
        .clock(clock), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len),
        .cnt_clear(cnt_clear), .cnt_load(cnt_load), .cnt_increment(cnt_increment),
        .cnt_I(cnt_I), .cnt_carry(cnt_carry), .busy(busy), .done(done),
        .carry_count(carry_count)
    );

    // Attached 4-bit counter; carry is the adder carry-out while incrementing at 4'hF
    always @(posedge clock) begin
        if (clear || cnt_clear) ctr_a <= 4'h0;
        else if (cnt_load)      ctr_a <= cnt_I;
        else if (cnt_increment) ctr_a <= ctr_a + 4'h1;
    end
    assign cnt_carry = force_carry | (cnt_increment && (ctr_a == 4'hF));

    typedef struct packed {
        logic       ready, busy, done, load, clr, inc;
        logic [3:0] cnt_i;
        logic [7:0] cc;
    } obs_t;

    obs_t exp_q[$];
    int m_a = 0, m_cnt_i = 0, m_cc = 0;

    function automatic obs_t idle_rec();
        obs_t r;
        r = '0;
        r.ready = 1'b1;
        r.cnt_i = 4'(m_cnt_i);
        r.cc    = 8'(m_cc);
        return r;
    endfunction

    function automatic obs_t busy_rec(bit ld, bit cl, bit in, bit dn, int ci, int cc);
        obs_t r;
        r = '0;
        r.busy = 1'b1;
        r.load = ld; r.clr = cl; r.inc = in; r.done = dn;
        r.cnt_i = 4'(ci);
        r.cc    = 8'(cc);
        return r;
    endfunction

    function automatic int sat(int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Expected trace of one accepted command, from the counter value arithmetic
    task automatic push_cmd(input int op, input int data, input int len);
        int incs, k;
        case (op)
            0: exp_q.push_back(busy_rec(0, 0, 0, 1, m_cnt_i, m_cc));
            1: begin
                exp_q.push_back(busy_rec(1, 0, 0, 0, data, m_cc));
                exp_q.push_back(busy_rec(0, 0, 0, 1, data, m_cc));
                m_cnt_i = data;
                m_a     = data;
            end
            3: begin
                exp_q.push_back(busy_rec(0, 1, 0, 0, m_cnt_i, m_cc));
                exp_q.push_back(busy_rec(0, 0, 0, 1, m_cnt_i, m_cc));
                m_a = 0;
            end
            default: begin
                incs = len;
`ifdef CARRY_STOP_EN
                k = 16 - m_a;
                if (len > 0 && k <= len) incs = k;
`else
                k = 0;
`endif
                for (int i = 1; i <= incs; i++)
                    exp_q.push_back(busy_rec(0, 0, 1, 0, m_cnt_i, sat((m_a + i - 1) / 16)));
                m_cc = sat((m_a + incs) / 16);
                exp_q.push_back(busy_rec(0, 0, 0, 1, m_cnt_i, m_cc));
                m_a = (m_a + incs) % 16;
            end
        endcase
    endtask

    // Per-cycle compare against the expectation queue (idle record when empty)
    always @(negedge clock) begin
        obs_t a, e;
        if (chk_en) begin
            a = '{cmd_ready, busy, done, cnt_load, cnt_clear, cnt_increment, cnt_I, carry_count};
            e = (exp_q.size() != 0) ? exp_q.pop_front() : idle_rec();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL cycle t=%0t got=%h want=%h", $time, a, e);
            end
            if (cnt_increment) inc_seen++;
            if (cnt_clear) clr_seen++;
        end
    end

    task automatic check_lit(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) check_lit("wait_idle_timeout", exp_q.size(), 0);
        #1;
    endtask

    // Offer a command in IDLE; optionally keep cmd_valid high with a LOAD until the command finishes
    task automatic send(input int op, input int data, input int len, input bit hold);
        int n = 0;
        wait_idle();
        @(posedge clock); #1;
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_data  = 4'(data);
        cmd_len   = 8'(len);
        @(posedge clock); #1;
        push_cmd(op, data, len);
        if (hold) begin
            cmd_op   = 2'b01;
            cmd_data = 4'h5;
            while (exp_q.size() != 0 && n < 300) begin
                @(negedge clock);
                n++;
            end
        end
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
    endtask

    initial begin
        int i0, c0;
        clear     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_data  = 4'h7;
        cmd_len   = 8'd0;
        repeat (2) @(posedge clock);
        #1;
        clear     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        chk_en    = 1'b1;
        @(negedge clock); #1;
        check_lit("reset_ready", int'(cmd_ready), 1);
        check_lit("reset_outs", int'({busy, done, cnt_load, cnt_clear, cnt_increment}), 0);
        check_lit("reset_cnt_I", int'(cnt_I), 0);

        // LOAD 4'hA with a stray carry outside RUN
        force_carry = 1'b1;
        send(1, 4'hA, 0, 1'b0);
        @(negedge clock); #1;
        check_lit("load_cnt_I_pulse", int'(cnt_I), 4'hA);
        wait_idle();
        force_carry = 1'b0;
        check_lit("load_cnt_I_hold", int'(cnt_I), 4'hA);
        check_lit("load_carry_ignored", int'(carry_count), 0);
        send(0, 0, 0, 1'b0);

        // LOAD E then RUN 5 across the wrap
        send(1, 4'hE, 0, 1'b0);
        wait_idle();
        i0 = inc_seen;
        send(2, 0, 5, 1'b0);
        wait_idle();
        check_lit("run5_carry_count", int'(carry_count), 1);
`ifdef CARRY_STOP_EN
        check_lit("run5_incs", inc_seen - i0, 2);
        check_lit("run5_counter", int'(ctr_a), 0);
`else
        check_lit("run5_incs", inc_seen - i0, 5);
        check_lit("run5_counter", int'(ctr_a), 3);
`endif

        // RUN of length zero
        i0 = inc_seen;
        send(2, 0, 0, 1'b0);
        check_lit("run0_done_next", int'(done), 1);
        wait_idle();
        check_lit("run0_incs", inc_seen - i0, 0);
        check_lit("run0_carry_count", int'(carry_count), 0);

        // ZERO then RUN 40 from zero
        send(3, 0, 0, 1'b0);
        send(2, 0, 40, 1'b0);
        wait_idle();
`ifdef CARRY_STOP_EN
        check_lit("run40_carry_count", int'(carry_count), 1);
`else
        check_lit("run40_carry_count", int'(carry_count), 2);
`endif

        // ZERO then RUN 40, clear during the tenth increment
        send(3, 0, 0, 1'b0);
        wait_idle();
        i0 = inc_seen;
        send(2, 0, 40, 1'b0);
        repeat (9) @(posedge clock);
        #1 clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        exp_q.delete();
        m_cc = 0; m_cnt_i = 0; m_a = 0;
        @(negedge clock); #1;
        check_lit("clear_incs", inc_seen - i0, 10);
        check_lit("clear_idle_outs", int'({cmd_ready, busy, done, cnt_load, cnt_clear, cnt_increment}), 6'b100000);
        check_lit("clear_data", int'({cnt_I, carry_count}), 0);

        // cmd_valid held through a busy RUN, then a single ZERO
        send(2, 0, 6, 1'b1);
        wait_idle();
        c0 = clr_seen;
        send(3, 0, 0, 1'b0);
        wait_idle();
        check_lit("zero_clr_once", clr_seen - c0, 1);
        check_lit("held_load_ignored", int'(cnt_I), 0);
        check_lit("zero_counter", int'(ctr_a), 0);

        repeat (3) @(posedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

endmodule
